// File: rtl/expr_stream_ctrl_pkg.sv
// rtl/expr_stream_ctrl_pkg.sv - shared types, character constants and classifiers
// Purpose: controller state enum, recognizer state enum, ASCII constants used by
//          the expression recognizer and its stream sequencer.
// Ports:   none (package).
package expr_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    C_START = 3'd0,
    C_NUM   = 3'd1,
    C_OP    = 3'd2,
    C_NUM2  = 3'd3,
    C_ERR   = 3'd4
  } char_state_t;

  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_PLUS) || (c == CH_STAR);
  endfunction

endpackage

// File: rtl/expr_stream_ctrl_if.sv
// rtl/expr_stream_ctrl_if.sv - byte-in / verdict-out handshake bundle
// Purpose: groups the input byte stream and the verdict channel.
// Ports:   in_valid/in_data/in_ready (byte stream), res_valid/res_ready/res_ok/
//          res_len/res_ops (verdict), busy (status).
//          slave  = sequencer side, master = producer/consumer side.
interface expr_stream_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             res_valid;
  logic             res_ready;
  logic             res_ok;
  logic [LEN_W-1:0] res_len;
  logic [LEN_W-1:0] res_ops;
  logic             busy;

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_ok, res_len, res_ops, busy
  );

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_ok, res_len, res_ops, busy
  );
endinterface

// File: rtl/expr_stream_ctrl_char_fsm.sv
// rtl/expr_stream_ctrl_char_fsm.sv - digit([+*]digit)* character recognizer
// Purpose: consumes one byte per feed strobe; out=1 while the bytes seen since
//          the last restart form a legal expression. ERR is absorbing.
// Ports:   clk, clr_n (sync active-low), restart (wins over feed), feed,
//          data (byte), out (legal so far).
module expr_char_fsm
  import expr_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       restart,
  input  logic       feed,
  input  logic [7:0] data,
  output logic       out
);

  char_state_t st, st_nxt;

  always_ff @(posedge clk) begin
    if (!clr_n || restart) st <= C_START;
    else if (feed)         st <= st_nxt;
  end

  // Any byte not explicitly allowed from the current state lands in ERR.
  always_comb begin
    st_nxt = C_ERR;
    case (st)
      C_START:       if (is_digit(data)) st_nxt = C_NUM;
      C_NUM, C_NUM2: if (is_op(data))    st_nxt = C_OP;
      C_OP:          if (is_digit(data)) st_nxt = C_NUM2;
      default:       st_nxt = C_ERR;
    endcase
  end

  assign out = (st == C_NUM) || (st == C_NUM2);

endmodule

// File: rtl/expr_stream_ctrl.sv
// rtl/expr_stream_ctrl.sv - FIFO-buffered sequencer for the expression recognizer
// Purpose: buffers an input byte stream, splits it into expressions on DELIM,
//          feeds the recognizer one byte per cycle and reports one verdict
//          (legal, length, operator count) per expression.
// Ports:   clk, clr_n (sync active-low reset),
//          bus.slave: in_valid/in_data/in_ready, res_valid/res_ready/res_ok/
//          res_len/res_ops, busy.
module expr_stream_ctrl
  import expr_pkg::*;
#(
  parameter int         DEPTH = 8,
  parameter int         LEN_W = 8,
  parameter logic [7:0] DELIM = 8'h3B
) (
  input  logic              clk,
  input  logic              clr_n,
  expr_stream_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  // FIFO: pointers carry one extra bit so full/empty differ only in the MSB.
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop;
  logic [7:0]  head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign push  = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Control FSM
  state_t state, state_nxt;
  logic   is_delim, feed, restart, rec_out, res_valid;

  assign is_delim = (head == DELIM);

  always_ff @(posedge clk) begin
    if (!clr_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_RUN: if (!empty) state_nxt = is_delim ? S_REPORT : S_RUN;
      S_REPORT:      if (bus.res_ready) state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = ((state == S_IDLE) || (state == S_RUN)) && !empty;
    feed      = pop && !is_delim;
    restart   = pop && is_delim;
    res_valid = (state == S_REPORT);
  end

  expr_char_fsm u_char_fsm (
    .clk     (clk),
    .clr_n   (clr_n),
    .restart (restart),
    .feed    (feed),
    .data    (head),
    .out     (rec_out)
  );

  // Running counters and the latched verdict. The verdict registers are only
  // written when DELIM is popped, so they hold steady throughout S_REPORT.
  logic [LEN_W-1:0] len, ops, res_len_q, res_ops_q;
  logic             res_ok_q;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      len       <= '0;
      ops       <= '0;
      res_ok_q  <= 1'b0;
      res_len_q <= '0;
      res_ops_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          if (is_delim) begin
            res_ok_q  <= 1'b0;
            res_len_q <= '0;
            res_ops_q <= '0;
            len       <= '0;
            ops       <= '0;
          end else begin
            len <= LEN_W'(1);
            ops <= LEN_W'(is_op(head));
          end
        end
        S_RUN: if (pop) begin
          if (is_delim) begin
            res_ok_q  <= rec_out;
            res_len_q <= len;
            res_ops_q <= ops;
          end else begin
            if (len != CNT_MAX)                 len <= len + 1'b1;
            if (is_op(head) && ops != CNT_MAX)  ops <= ops + 1'b1;
          end
        end
        S_REPORT: if (bus.res_ready) begin
          len <= '0;
          ops <= '0;
        end
        default: ;
      endcase
    end
  end

  // in_ready is held low while reset is asserted.
  assign bus.in_ready  = clr_n && !full;
  assign bus.res_valid = res_valid;
  assign bus.res_ok    = res_ok_q;
  assign bus.res_len   = res_len_q;
  assign bus.res_ops   = res_ops_q;
  assign bus.busy      = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_expr_stream_ctrl.sv
// tb/tb_expr_stream_ctrl.sv - directed self-checking bench for expr_stream_ctrl
module tb_expr_stream_ctrl;
  import expr_pkg::*;

  logic clk = 1'b0;
  logic clr_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  expr_stream_ctrl_if #(.LEN_W(8)) ifa ();
  expr_stream_ctrl_if #(.LEN_W(4)) ifb ();

  expr_stream_ctrl #(.DEPTH(8), .LEN_W(8), .DELIM(8'h3B)) dut_a (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifa)
  );

  expr_stream_ctrl #(.DEPTH(8), .LEN_W(4), .DELIM(8'h3B)) dut_b (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (ifb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? ifb.in_ready : ifa.in_ready;
  endfunction

  task automatic push_byte(input bit sel, input logic [7:0] b);
    int n = 0;
    if (sel) begin ifb.in_valid = 1'b1; ifb.in_data = b; end
    else     begin ifa.in_valid = 1'b1; ifa.in_data = b; end
    while (!rdy(sel) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_ready", 32'(rdy(sel)), 32'd1);
    @(posedge clk); #1;
    if (sel) ifb.in_valid = 1'b0;
    else     ifa.in_valid = 1'b0;
  endtask

  task automatic push_str(input bit sel, input string s);
    for (int i = 0; i < s.len(); i++) push_byte(sel, s[i]);
  endtask

  task automatic collect(input bit sel, input string tag,
                         input int ok, input int len, input int ops);
    int n = 0;
    while (!(sel ? ifb.res_valid : ifa.res_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_valid"}, 32'(sel ? ifb.res_valid : ifa.res_valid), 32'd1);
    chk({tag, "_ok"},    32'(sel ? ifb.res_ok : ifa.res_ok), 32'(ok));
    chk({tag, "_len"},   sel ? 32'(ifb.res_len) : 32'(ifa.res_len), 32'(len));
    chk({tag, "_ops"},   sel ? 32'(ifb.res_ops) : 32'(ifa.res_ops), 32'(ops));
    if (sel) ifb.res_ready = 1'b1; else ifa.res_ready = 1'b1;
    @(posedge clk); #1;
    if (sel) ifb.res_ready = 1'b0; else ifa.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = 8'h00; ifa.res_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = 8'h00; ifb.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset values
    chk("rst_in_ready_low", 32'(ifa.in_ready), 32'd0);
    clr_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("rst_res_valid", 32'(ifa.res_valid), 32'd0);
    chk("rst_res_ok", 32'(ifa.res_ok), 32'd0);
    chk("rst_res_len", 32'(ifa.res_len), 32'd0);
    chk("rst_res_ops", 32'(ifa.res_ops), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);

    // 1: legal expression with two operators
    push_str(0, "1+2*3;");
    chk("t1_busy", 32'(ifa.busy), 32'd1);
    collect(0, "t1", 1, 5, 2);
    chk("t1_busy_after", 32'(ifa.busy), 32'd0);

    // 2: two illegal expressions, independent counts
    push_str(0, "12;+3;");
    collect(0, "t2a", 0, 2, 0);
    collect(0, "t2b", 0, 2, 1);

    // 3: empty expressions then a single digit
    push_str(0, ";;7;");
    collect(0, "t3a", 0, 0, 0);
    collect(0, "t3b", 0, 0, 0);
    collect(0, "t3c", 1, 1, 0);

    // 4: backpressure with the consumer stalled
    push_str(0, "1+1;1+1;1+1;");
    chk("t4_full", 32'(ifa.in_ready), 32'd0);
    chk("t4_valid", 32'(ifa.res_valid), 32'd1);
    chk("t4_len_hold0", 32'(ifa.res_len), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_len_hold1", 32'(ifa.res_len), 32'd3);
    chk("t4_ok_hold", 32'(ifa.res_ok), 32'd1);
    chk("t4_still_full", 32'(ifa.in_ready), 32'd0);
    collect(0, "t4a", 1, 3, 1);
    collect(0, "t4b", 1, 3, 1);
    collect(0, "t4c", 1, 3, 1);
    chk("t4_ready_after", 32'(ifa.in_ready), 32'd1);
    chk("t4_busy_after", 32'(ifa.busy), 32'd0);

    // 5: saturation with LEN_W=4 (19 bytes: 10 digits, 9 operators)
    push_str(1, "1+1+1+1+1+1+1+1+1+1;");
    collect(1, "t5", 1, 15, 9);

    // 6: reset mid-expression
    push_str(0, "5+");
    chk("t6_busy_pre", 32'(ifa.busy), 32'd1);
    clr_n = 1'b0;
    #1;
    chk("t6_in_ready_rst", 32'(ifa.in_ready), 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    #1;
    chk("t6_res_valid", 32'(ifa.res_valid), 32'd0);
    chk("t6_res_ok", 32'(ifa.res_ok), 32'd0);
    chk("t6_res_len", 32'(ifa.res_len), 32'd0);
    chk("t6_res_ops", 32'(ifa.res_ops), 32'd0);
    chk("t6_busy", 32'(ifa.busy), 32'd0);
    chk("t6_in_ready", 32'(ifa.in_ready), 32'd1);
    push_str(0, "4;");
    collect(0, "t6", 1, 1, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_extra", 32'(ifa.res_valid), 32'd0);
    chk("t6_idle", 32'(ifa.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
